// File: rtl/lightbike_arena.sv
// Lightbike game engine: round FSM, grid clear, per-tick movement, collisions, scoring and match end.
// Optional build macro LBIKE_WRAP_EN makes arena edges wrap instead of eliminating the rider.
module lightbike_arena #(
  parameter int NUM_PLAYERS = 2,
  parameter int GRID_W      = 50,
  parameter int GRID_H      = 50,
  parameter int COORD_W     = 6,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           start,
  input  logic [NUM_PLAYERS-1:0]         dir_valid,
  input  logic [2*NUM_PLAYERS-1:0]       dir_req,
  input  logic [COORD_W-1:0]             rd_x,
  input  logic [COORD_W-1:0]             rd_y,
  output logic                           rd_occ,
  output logic [NUM_PLAYERS-1:0]         rd_head,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_x,
  output logic [COORD_W*NUM_PLAYERS-1:0] pos_y,
  output logic [NUM_PLAYERS-1:0]         alive,
  output logic [SCORE_W*NUM_PLAYERS-1:0] scores,
  output logic [2:0]                     winner,
  output logic [4:0]                     state_o
);

  localparam logic [1:0] D_UP    = 2'd0;
  localparam logic [1:0] D_RIGHT = 2'd1;
  localparam logic [1:0] D_DOWN  = 2'd2;
  localparam logic [1:0] D_LEFT  = 2'd3;
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);
  localparam logic [SCORE_W-1:0] WIN   = SCORE_W'(WIN_SCORE);

`ifdef LBIKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Encoded one-hot so the state register is the status output directly.
  typedef enum logic [4:0] {
    S_CLEAR      = 5'b00001,
    S_READY      = 5'b00010,
    S_RUN        = 5'b00100,
    S_ROUND_OVER = 5'b01000,
    S_MATCH_OVER = 5'b10000
  } state_t;

  state_t state, state_nxt;

  logic [GRID_W-1:0]  grid [GRID_H];
  logic [COORD_W-1:0] row_cnt;
  logic [COORD_W-1:0] head_x   [NUM_PLAYERS];
  logic [COORD_W-1:0] head_y   [NUM_PLAYERS];
  logic [COORD_W-1:0] nxt_x    [NUM_PLAYERS];
  logic [COORD_W-1:0] nxt_y    [NUM_PLAYERS];
  logic [1:0]         cur_dir  [NUM_PLAYERS];
  logic [1:0]         pend_dir [NUM_PLAYERS];
  logic [SCORE_W-1:0] score    [NUM_PLAYERS];
  logic [NUM_PLAYERS-1:0] edge_hit, fault, alive_nxt;
  logic [2:0] surv_cnt;
  logic [2:0] surv_id;
  logic       run_tick, round_end, any_win, rd_in;

  function automatic logic [COORD_W-1:0] spawn_x(input int k);
    case (k)
      0:       return COORD_W'(GRID_W / 4);
      1:       return COORD_W'((3 * GRID_W) / 4);
      default: return COORD_W'(GRID_W / 2);
    endcase
  endfunction

  function automatic logic [COORD_W-1:0] spawn_y(input int k);
    case (k)
      2:       return COORD_W'(GRID_H / 4);
      3:       return COORD_W'((3 * GRID_H) / 4);
      default: return COORD_W'(GRID_H / 2);
    endcase
  endfunction

  function automatic logic [1:0] spawn_dir(input int k);
    case (k)
      0:       return D_RIGHT;
      1:       return D_LEFT;
      2:       return D_DOWN;
      default: return D_UP;
    endcase
  endfunction

  assign run_tick  = (state == S_RUN) && tick;
  assign round_end = (surv_cnt <= 3'd1);
  assign rd_in     = (rd_x <= X_MAX) && (rd_y <= Y_MAX);
  assign state_o   = state;

  // Next cell is always folded back into the grid so it can index the grid safely;
  // edge_hit records whether that fold was a real exit.
  always_comb begin
    edge_hit = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      nxt_x[k] = head_x[k];
      nxt_y[k] = head_y[k];
      case (pend_dir[k])
        D_UP: begin
          if (head_y[k] == '0) begin
            nxt_y[k] = Y_MAX;
            edge_hit[k] = ~WRAP_EN;
          end else nxt_y[k] = head_y[k] - 1'b1;
        end
        D_DOWN: begin
          if (head_y[k] == Y_MAX) begin
            nxt_y[k] = '0;
            edge_hit[k] = ~WRAP_EN;
          end else nxt_y[k] = head_y[k] + 1'b1;
        end
        D_RIGHT: begin
          if (head_x[k] == X_MAX) begin
            nxt_x[k] = '0;
            edge_hit[k] = ~WRAP_EN;
          end else nxt_x[k] = head_x[k] + 1'b1;
        end
        default: begin
          if (head_x[k] == '0) begin
            nxt_x[k] = X_MAX;
            edge_hit[k] = ~WRAP_EN;
          end else nxt_x[k] = head_x[k] - 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    fault     = '0;
    alive_nxt = '0;
    surv_cnt  = '0;
    surv_id   = 3'b111;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      fault[k] = edge_hit[k] | grid[nxt_y[k]][nxt_x[k]];
      for (int j = 0; j < NUM_PLAYERS; j++) begin
        if (j != k && alive[j]) begin
          if (nxt_x[k] == head_x[j] && nxt_y[k] == head_y[j]) fault[k] = 1'b1;
          // A rider leaving the grid never lands on its folded cell.
          if (!edge_hit[j] && nxt_x[k] == nxt_x[j] && nxt_y[k] == nxt_y[j]) fault[k] = 1'b1;
        end
      end
      alive_nxt[k] = alive[k] & ~fault[k];
      if (alive_nxt[k]) begin
        surv_cnt = surv_cnt + 3'd1;
        surv_id  = 3'(k);
      end
    end
  end

  always_comb begin
    any_win = 1'b0;
    for (int k = 0; k < NUM_PLAYERS; k++)
      if (score[k] == WIN) any_win = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_CLEAR:      if (row_cnt == Y_MAX) state_nxt = S_READY;
      S_READY:      if (start) state_nxt = S_RUN;
      S_RUN:        if (tick && round_end) state_nxt = S_ROUND_OVER;
      S_ROUND_OVER: if (start) state_nxt = any_win ? S_MATCH_OVER : S_CLEAR;
      S_MATCH_OVER: if (start) state_nxt = S_CLEAR;
      default:      state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) row_cnt <= '0;
    else if (state == S_CLEAR) row_cnt <= (row_cnt == Y_MAX) ? '0 : row_cnt + 1'b1;
    else row_cnt <= '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alive <= '1;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        head_x[k]   <= spawn_x(k);
        head_y[k]   <= spawn_y(k);
        cur_dir[k]  <= spawn_dir(k);
        pend_dir[k] <= spawn_dir(k);
      end
    end else if (state == S_CLEAR) begin
      alive <= '1;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        head_x[k]   <= spawn_x(k);
        head_y[k]   <= spawn_y(k);
        cur_dir[k]  <= spawn_dir(k);
        pend_dir[k] <= spawn_dir(k);
      end
    end else begin
      for (int k = 0; k < NUM_PLAYERS; k++) begin
        if (dir_valid[k] && (dir_req[2*k +: 2] != (cur_dir[k] ^ 2'd2)))
          pend_dir[k] <= dir_req[2*k +: 2];
        if (run_tick) begin
          cur_dir[k] <= pend_dir[k];
          if (alive_nxt[k]) begin
            head_x[k] <= nxt_x[k];
            head_y[k] <= nxt_y[k];
          end
        end
      end
      if (run_tick) alive <= alive_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      winner <= 3'b111;
      for (int k = 0; k < NUM_PLAYERS; k++) score[k] <= '0;
    end else if (run_tick && round_end) begin
      winner <= (surv_cnt == 3'd1) ? surv_id : 3'b111;
      for (int k = 0; k < NUM_PLAYERS; k++)
        if (surv_cnt == 3'd1 && surv_id == 3'(k) && score[k] < WIN)
          score[k] <= score[k] + 1'b1;
    end else if (state == S_MATCH_OVER && start) begin
      winner <= 3'b111;
      for (int k = 0; k < NUM_PLAYERS; k++) score[k] <= '0;
    end
  end

  // Grid has no reset: its contents are only meaningful once CLEAR has swept every row.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) grid[row_cnt] <= '0;
    else if (run_tick) begin
      for (int k = 0; k < NUM_PLAYERS; k++)
        if (alive[k]) grid[head_y[k]][head_x[k]] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_occ  <= 1'b0;
      rd_head <= '0;
    end else begin
      rd_occ <= rd_in ? grid[rd_y][rd_x] : 1'b1;
      for (int k = 0; k < NUM_PLAYERS; k++)
        rd_head[k] <= rd_in && (head_x[k] == rd_x) && (head_y[k] == rd_y);
    end
  end

  always_comb begin
    pos_x  = '0;
    pos_y  = '0;
    scores = '0;
    for (int k = 0; k < NUM_PLAYERS; k++) begin
      pos_x[k*COORD_W +: COORD_W]  = head_x[k];
      pos_y[k*COORD_W +: COORD_W]  = head_y[k];
      scores[k*SCORE_W +: SCORE_W] = score[k];
    end
  end

endmodule

// File: tb/tb_lightbike_arena.sv
// Bench for lightbike_arena: a vector table checked through a scoreboard queue, then full rounds
// (edge death, head swap, same-cell collision on a 48x8 arena, match end, async reset).
module tb_lightbike_arena;
  localparam int NP = 2;
  localparam int CW = 6;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic tick = 1'b0, start = 1'b0;
  logic [NP-1:0] dir_valid = '0;
  logic [2*NP-1:0] dir_req = '0;
  logic [CW-1:0] rd_x = '0, rd_y = '0;
  logic rd_occ;
  logic [NP-1:0] rd_head, alive;
  logic [CW*NP-1:0] pos_x, pos_y;
  logic [SW*NP-1:0] scores;
  logic [2:0] winner;
  logic [4:0] state_o;

  logic s_tick = 1'b0, s_start = 1'b0;
  logic s_rd_occ;
  logic [NP-1:0] s_rd_head, s_alive;
  logic [CW*NP-1:0] s_pos_x, s_pos_y;
  logic [SW*NP-1:0] s_scores;
  logic [2:0] s_winner;
  logic [4:0] s_state_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lightbike_arena dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .dir_valid(dir_valid), .dir_req(dir_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_occ(rd_occ), .rd_head(rd_head), .pos_x(pos_x), .pos_y(pos_y),
    .alive(alive), .scores(scores), .winner(winner), .state_o(state_o)
  );

  lightbike_arena #(.GRID_W(48), .GRID_H(8)) dut_s (
    .clk(clk), .reset(reset), .tick(s_tick), .start(s_start),
    .dir_valid(2'b00), .dir_req(4'b0000), .rd_x(rd_x), .rd_y(rd_y),
    .rd_occ(s_rd_occ), .rd_head(s_rd_head), .pos_x(s_pos_x), .pos_y(s_pos_y),
    .alive(s_alive), .scores(s_scores), .winner(s_winner), .state_o(s_state_o)
  );

  typedef struct {
    logic       tk, st;
    logic [1:0] dv;
    logic [3:0] dr;
    logic [5:0] qx, qy;
    logic [4:0] e_state;
    logic [1:0] e_alive;
    logic [5:0] e_p0x, e_p1x;
    logic       e_occ;
    logic [1:0] e_head;
  } vec_t;

  typedef struct {
    int         idx;
    logic [4:0] st;
    logic [1:0] alv;
    logic [5:0] p0x, p1x;
    logic       occ;
    logic [1:0] head;
  } exp_t;

  vec_t vt[14];
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) cyc();
    tick = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic steer(input logic [1:0] dv, input logic [3:0] dr);
    dir_valid = dv;
    dir_req   = dr;
    cyc();
    dir_valid = '0;
  endtask

  function automatic vec_t mk(input logic tk, input logic st, input logic [1:0] dv, input logic [3:0] dr,
                              input int qx, input int qy, input logic [4:0] es, input logic [1:0] ea,
                              input int p0, input int p1, input logic eo, input logic [1:0] eh);
    vec_t v;
    v.tk = tk; v.st = st; v.dv = dv; v.dr = dr;
    v.qx = 6'(qx); v.qy = 6'(qy);
    v.e_state = es; v.e_alive = ea;
    v.e_p0x = 6'(p0); v.e_p1x = 6'(p1);
    v.e_occ = eo; v.e_head = eh;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    // tick start dv   dr       qx  qy  state  alive p0x p1x occ head
    vt[0]  = mk(1, 0, 2'b00, 4'b0000,  0,  0, 5'd2, 2'b11, 12, 37, 0, 2'b00);
    vt[1]  = mk(0, 1, 2'b00, 4'b0000, 12, 25, 5'd4, 2'b11, 12, 37, 0, 2'b01);
    vt[2]  = mk(1, 0, 2'b00, 4'b0000, 12, 25, 5'd4, 2'b11, 13, 36, 0, 2'b01);
    vt[3]  = mk(1, 0, 2'b00, 4'b0000, 12, 25, 5'd4, 2'b11, 14, 35, 1, 2'b00);
    vt[4]  = mk(1, 0, 2'b00, 4'b0000, 13, 25, 5'd4, 2'b11, 15, 34, 1, 2'b00);
    vt[5]  = mk(0, 0, 2'b00, 4'b0000, 14, 25, 5'd4, 2'b11, 15, 34, 1, 2'b00);
    vt[6]  = mk(0, 0, 2'b00, 4'b0000, 15, 25, 5'd4, 2'b11, 15, 34, 0, 2'b01);
    vt[7]  = mk(0, 0, 2'b01, 4'b0011, 34, 25, 5'd4, 2'b11, 15, 34, 0, 2'b10);
    vt[8]  = mk(1, 0, 2'b00, 4'b0000, 37, 25, 5'd4, 2'b11, 16, 33, 1, 2'b00);
    vt[9]  = mk(1, 1, 2'b00, 4'b0000, 50,  0, 5'd4, 2'b11, 17, 32, 1, 2'b00);
    vt[10] = mk(0, 0, 2'b00, 4'b0000, 63, 63, 5'd4, 2'b11, 17, 32, 1, 2'b00);
    vt[11] = mk(0, 0, 2'b00, 4'b0000, 49, 49, 5'd4, 2'b11, 17, 32, 0, 2'b00);
    vt[12] = mk(0, 0, 2'b00, 4'b0000,  0, 50, 5'd4, 2'b11, 17, 32, 1, 2'b00);
    vt[13] = mk(0, 0, 2'b00, 4'b0000, 16, 25, 5'd4, 2'b11, 17, 32, 1, 2'b00);

    repeat (3) cyc();
    check("rst_state", 32'(state_o), 32'h01);
    check("rst_alive", 32'(alive), 32'h3);
    check("rst_winner", 32'(winner), 32'h7);
    check("rst_scores", 32'(scores), 32'h00);
    check("rst_pos_x", 32'(pos_x), {20'd0, 6'd37, 6'd12});
    check("rst_pos_y", 32'(pos_y), {20'd0, 6'd25, 6'd25});
    check("rst_rd", 32'({rd_occ, rd_head}), 32'h0);

    reset = 1'b1;
    // Start, a tick and a steering request inside CLEAR must all be ignored.
    for (int i = 0; i < 49; i++) begin
      start = (i == 10);
      tick  = (i == 20);
      dir_valid = (i == 10) ? 2'b01 : 2'b00;
      dir_req   = 4'b0000;
      cyc();
    end
    start = 1'b0; tick = 1'b0; dir_valid = '0;
    check("clear_len", 32'(state_o), 32'h01);
    cyc();
    check("clear_done", 32'(state_o), 32'h02);

    for (int i = 0; i < 14; i++) begin
      tick = vt[i].tk; start = vt[i].st;
      dir_valid = vt[i].dv; dir_req = vt[i].dr;
      rd_x = vt[i].qx; rd_y = vt[i].qy;
      sb.push_back('{i, vt[i].e_state, vt[i].e_alive, vt[i].e_p0x, vt[i].e_p1x, vt[i].e_occ, vt[i].e_head});
      cyc();
      tick = 1'b0; start = 1'b0; dir_valid = '0;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_empty: got 0 entries expected 1");
      end else begin
        e = sb.pop_front();
        check($sformatf("v%0d_state", e.idx), 32'(state_o), 32'(e.st));
        check($sformatf("v%0d_alive", e.idx), 32'(alive), 32'(e.alv));
        check($sformatf("v%0d_p0x", e.idx), 32'(pos_x[5:0]), 32'(e.p0x));
        check($sformatf("v%0d_p1x", e.idx), 32'(pos_x[11:6]), 32'(e.p1x));
        check($sformatf("v%0d_occ", e.idx), 32'(rd_occ), 32'(e.occ));
        check($sformatf("v%0d_head", e.idx), 32'(rd_head), 32'(e.head));
      end
    end

    // Round 1: P0 climbs to the top edge and rides off it; P1 turns down out of the way.
    steer(2'b01, 4'b0000);
    ticks(10);
    steer(2'b10, 4'b1000);
    ticks(15);
    check("r1_pre_p0y", 32'(pos_y[5:0]), 32'd0);
    check("r1_pre_p1", 32'({pos_x[11:6], pos_y[11:6]}), {20'd0, 6'd22, 6'd40});
    check("r1_pre_state", 32'(state_o), 32'h04);
    check("r1_pre_alive", 32'(alive), 32'h3);
    ticks(1);
    check("r1_alive", 32'(alive), 32'h2);
    check("r1_state", 32'(state_o), 32'h08);
    check("r1_winner", 32'(winner), 32'h1);
    check("r1_scores", 32'(scores), 32'h10);
    check("r1_p0_frozen", 32'({pos_x[5:0], pos_y[5:0]}), {20'd0, 6'd17, 6'd0});
    rd_x = 6'd17; rd_y = 6'd0;
    cyc();
    check("r1_rd_occ", 32'(rd_occ), 32'h1);
    check("r1_rd_head", 32'(rd_head), 32'h1);

    // Round 2: straight head-on ride ends in a head swap, both eliminated.
    pulse_start();
    check("r2_clear", 32'(state_o), 32'h01);
    repeat (50) cyc();
    check("r2_ready", 32'(state_o), 32'h02);
    check("r2_respawn", 32'(pos_x), {20'd0, 6'd37, 6'd12});
    check("r2_scores_kept", 32'(scores), 32'h10);
    pulse_start();
    ticks(12);
    check("r2_pre_pos", 32'(pos_x), {20'd0, 6'd25, 6'd24});
    check("r2_pre_alive", 32'(alive), 32'h3);
    ticks(1);
    check("r2_alive", 32'(alive), 32'h0);
    check("r2_state", 32'(state_o), 32'h08);
    check("r2_winner", 32'(winner), 32'h7);
    check("r2_scores", 32'(scores), 32'h10);
    check("r2_frozen", 32'(pos_x), {20'd0, 6'd25, 6'd24});

    // Rounds 3..10: P0 rides off the bottom, P1 climbs safely and wins each time.
    for (int r = 0; r < 8; r++) begin
      pulse_start();
      check($sformatf("m%0d_clear", r), 32'(state_o), 32'h01);
      repeat (50) cyc();
      steer(2'b11, 4'b0010);
      pulse_start();
      ticks(24);
      check($sformatf("m%0d_pre_alive", r), 32'(alive), 32'h3);
      ticks(1);
      check($sformatf("m%0d_state", r), 32'(state_o), 32'h08);
      check($sformatf("m%0d_winner", r), 32'(winner), 32'h1);
      check($sformatf("m%0d_scores", r), 32'(scores), 32'((r + 2) << 4));
    end
    pulse_start();
    check("match_over", 32'(state_o), 32'h10);
    check("match_scores", 32'(scores), 32'h90);
    pulse_start();
    check("match_restart", 32'(state_o), 32'h01);
    check("match_scores0", 32'(scores), 32'h00);
    check("match_winner", 32'(winner), 32'h7);

    // Even spacing on a 48x8 arena: both riders aim at the same cell on one tick.
    check("s_ready", 32'(s_state_o), 32'h02);
    s_start = 1'b1; cyc(); s_start = 1'b0;
    s_tick = 1'b1; repeat (11) cyc(); s_tick = 1'b0;
    check("s_pre_pos", 32'(s_pos_x), {20'd0, 6'd25, 6'd23});
    check("s_pre_alive", 32'(s_alive), 32'h3);
    s_tick = 1'b1; cyc(); s_tick = 1'b0;
    check("s_alive", 32'(s_alive), 32'h0);
    check("s_state", 32'(s_state_o), 32'h08);
    check("s_winner", 32'(s_winner), 32'h7);
    check("s_scores", 32'(s_scores), 32'h00);
    check("s_frozen", 32'(s_pos_x), {20'd0, 6'd25, 6'd23});

    // Reset asserted mid-round returns everything at once, without a clock edge.
    repeat (50) cyc();
    pulse_start();
    rd_x = 6'd12; rd_y = 6'd25;
    ticks(3);
    check("mid_pos", 32'(pos_x), {20'd0, 6'd34, 6'd15});
    check("mid_occ", 32'(rd_occ), 32'h1);
    reset = 1'b0;
    #2;
    check("arst_state", 32'(state_o), 32'h01);
    check("arst_pos", 32'(pos_x), {20'd0, 6'd37, 6'd12});
    check("arst_occ", 32'(rd_occ), 32'h0);
    check("arst_s_state", 32'(s_state_o), 32'h01);
    reset = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
